// File: rtl/config_pkg.sv
// Shared constants and op codes for the config screen tilemap (writer and renderer).
package config_pkg;

  localparam int CFG_TILE_BASE = 2048;
  localparam int CFG_COLS      = 40;
  localparam int CFG_ROWS      = 23;

  typedef enum logic [1:0] {
    CFG_OP_PUT   = 2'd0,
    CFG_OP_FILL  = 2'd1,
    CFG_OP_CLEAR = 2'd2,
    CFG_OP_RSVD  = 2'd3
  } cfg_op_t;

endpackage

// File: rtl/config_tilemap_writer.sv
// Tilemap write engine: takes PUT/FILL/CLEAR commands and streams one RAM
// write per cycle over the clipped rectangle, row-major.
module config_tilemap_writer
  import config_pkg::*;
#(
  parameter int TILE_BASE = CFG_TILE_BASE,
  parameter int COLS      = CFG_COLS,
  parameter int ROWS      = CFG_ROWS
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_op_in,
  input  logic [5:0]  cmd_x_in,
  input  logic [4:0]  cmd_y_in,
  input  logic [5:0]  cmd_w_in,
  input  logic [4:0]  cmd_h_in,
  input  logic [7:0]  cmd_tile_in,
  output logic [11:0] mem_addr_out,
  output logic        mem_we_out,
  output logic [7:0]  mem_din_out,
  output logic        busy_out,
  output logic        done_out
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state, state_nx;
  logic [5:0]  col, col_start;
  logic [4:0]  row;
  logic [6:0]  col_end;
  logic [5:0]  row_end;
  logic [11:0] row_base;

  cfg_op_t     op;
  logic [5:0]  rx, rw;
  logic [4:0]  ry, rh;
  logic [6:0]  x_end_raw, col_lim;
  logic [5:0]  y_end_raw, row_lim;
  logic [11:0] rb_init;
  logic        empty, accept, col_last, row_last;

  assign cmd_ready_out = (state == IDLE);
  assign accept        = cmd_valid_in && cmd_ready_out;
  // A write is in flight exactly when the write strobe is up.
  assign busy_out      = mem_we_out;

  // Region decode, clipping, first-row base address and next state.
  always_comb begin
    op = cfg_op_t'(cmd_op_in);
    rx = cmd_x_in;
    ry = cmd_y_in;
    rw = cmd_w_in;
    rh = cmd_h_in;
    case (op)
      CFG_OP_PUT:   begin rw = 6'd1; rh = 5'd1; end
      CFG_OP_CLEAR: begin rx = '0; ry = '0; rw = 6'(COLS); rh = 5'(ROWS); end
      CFG_OP_RSVD:  rw = '0;
      default:      ;
    endcase
    // Sums are one bit wider than the operands so they cannot wrap.
    x_end_raw = {1'b0, rx} + {1'b0, rw};
    y_end_raw = {1'b0, ry} + {1'b0, rh};
    col_lim   = (x_end_raw > 7'(COLS)) ? 7'(COLS) : x_end_raw;
    row_lim   = (y_end_raw > 6'(ROWS)) ? 6'(ROWS) : y_end_raw;
    empty     = ({1'b0, rx} >= 7'(COLS)) || ({1'b0, ry} >= 6'(ROWS)) ||
                (rw == '0) || (rh == '0);
    // row*40 as row*32 + row*8, no multiplier.
    rb_init   = 12'(TILE_BASE) + ({7'd0, ry} << 5) + ({7'd0, ry} << 3) + {6'd0, rx};
    col_last  = (({1'b0, col} + 7'd1) == col_end);
    row_last  = (({1'b0, row} + 6'd1) == row_end);

    state_nx = state;
    case (state)
      IDLE:  if (accept && !empty) state_nx = WRITE;
      WRITE: if (col_last && row_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM register, scan counters and registered RAM write port.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      col          <= '0;
      col_start    <= '0;
      row          <= '0;
      col_end      <= '0;
      row_end      <= '0;
      row_base     <= '0;
      mem_addr_out <= '0;
      mem_we_out   <= 1'b0;
      mem_din_out  <= '0;
      done_out     <= 1'b0;
    end else begin
      state    <= state_nx;
      done_out <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (empty) begin
            done_out <= 1'b1;
          end else begin
            col          <= rx;
            col_start    <= rx;
            row          <= ry;
            col_end      <= col_lim;
            row_end      <= row_lim;
            row_base     <= rb_init;
            mem_addr_out <= rb_init;
            mem_din_out  <= cmd_tile_in;
            mem_we_out   <= 1'b1;
          end
        end
        WRITE: begin
          if (!col_last) begin
            col          <= col + 6'd1;
            mem_addr_out <= mem_addr_out + 12'd1;
          end else if (!row_last) begin
            col          <= col_start;
            row          <= row + 5'd1;
            row_base     <= row_base + 12'(COLS);
            mem_addr_out <= row_base + 12'(COLS);
          end else begin
            mem_we_out <= 1'b0;
            done_out   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_tilemap_writer.sv
// Self-checking bench: directed table, back-to-back and reset sequences,
// plus random commands checked against a rectangle-enumerating model.
module tb_config_tilemap_writer;
  import config_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [1:0]  cmd_op_in = '0;
  logic [5:0]  cmd_x_in = '0;
  logic [4:0]  cmd_y_in = '0;
  logic [5:0]  cmd_w_in = '0;
  logic [4:0]  cmd_h_in = '0;
  logic [7:0]  cmd_tile_in = '0;
  logic [11:0] mem_addr_out;
  logic        mem_we_out;
  logic [7:0]  mem_din_out;
  logic        busy_out;
  logic        done_out;

  config_tilemap_writer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_x_in(cmd_x_in), .cmd_y_in(cmd_y_in),
    .cmd_w_in(cmd_w_in), .cmd_h_in(cmd_h_in), .cmd_tile_in(cmd_tile_in),
    .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out), .mem_din_out(mem_din_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0] op;
    logic [5:0] x;
    logic [4:0] y;
    logic [5:0] w;
    logic [4:0] h;
    logic [7:0] tile;
    int         k;
    int         first;
    int         last;
  } vec_t;

  vec_t vecs[10];
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected write addresses: enumerate the clipped rectangle directly.
  task automatic model(input int op, input int x, input int y, input int w, input int h);
    int x0, y0, w0, h0;
    exp_q.delete();
    x0 = x; y0 = y; w0 = w; h0 = h;
    case (op)
      0: begin w0 = 1; h0 = 1; end
      2: begin x0 = 0; y0 = 0; w0 = CFG_COLS; h0 = CFG_ROWS; end
      3: w0 = 0;
      default: ;
    endcase
    for (int r = y0; r < y0 + h0 && r < CFG_ROWS; r++)
      for (int c = x0; c < x0 + w0 && c < CFG_COLS; c++)
        exp_q.push_back(CFG_TILE_BASE + CFG_COLS * r + c);
  endtask

  // Issue one command from a negedge and follow it to its done cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] x, input logic [4:0] y,
                         input logic [5:0] w, input logic [4:0] h, input logic [7:0] tile,
                         output int kexp, output int nw, output int first, output int last);
    int idx;
    model(op, x, y, w, h);
    kexp = exp_q.size();
    nw = 0; first = -1; last = -1;
    cmd_op_in = op; cmd_x_in = x; cmd_y_in = y; cmd_w_in = w; cmd_h_in = h;
    cmd_tile_in = tile; cmd_valid_in = 1'b1;
    @(posedge clk_in);
    #1 cmd_valid_in = 1'b0;
    for (int cyc = 1; cyc <= kexp + 1; cyc++) begin
      @(negedge clk_in);
      check("ctl{we,rdy,done,busy}", int'({mem_we_out, cmd_ready_out, done_out, busy_out}),
            int'({cyc <= kexp, cyc > kexp, cyc == kexp + 1, cyc <= kexp}));
      if (mem_we_out) begin
        idx = cyc - 1;
        if (idx < kexp) begin
          check("addr", int'(mem_addr_out), exp_q[idx]);
          check("din", int'(mem_din_out), int'(tile));
        end
        if (first < 0) first = int'(mem_addr_out);
        last = int'(mem_addr_out);
        nw++;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int kexp, nw, first, last;
    vecs[0] = '{2'd0, 6'd3,  5'd2,  6'd0,  5'd0,  8'h41, 1,   2131, 2131};
    vecs[1] = '{2'd1, 6'd38, 5'd21, 6'd5,  5'd4,  8'h07, 4,   2926, 2967};
    vecs[2] = '{2'd2, 6'd0,  5'd0,  6'd0,  5'd0,  8'h20, 920, 2048, 2967};
    vecs[3] = '{2'd1, 6'd5,  5'd5,  6'd0,  5'd3,  8'h01, 0,   -1,   -1};
    vecs[4] = '{2'd0, 6'd40, 5'd0,  6'd0,  5'd0,  8'h02, 0,   -1,   -1};
    vecs[5] = '{2'd3, 6'd1,  5'd1,  6'd2,  5'd2,  8'h03, 0,   -1,   -1};
    vecs[6] = '{2'd1, 6'd0,  5'd0,  6'd63, 5'd31, 8'h09, 920, 2048, 2967};
    vecs[7] = '{2'd1, 6'd10, 5'd3,  6'd3,  5'd1,  8'h5A, 3,   2178, 2180};
    vecs[8] = '{2'd0, 6'd39, 5'd22, 6'd0,  5'd0,  8'hFF, 1,   2967, 2967};
    vecs[9] = '{2'd1, 6'd2,  5'd23, 6'd4,  5'd4,  8'h04, 0,   -1,   -1};

    // Reset values
    #12;
    check("rst addr", int'(mem_addr_out), 0);
    check("rst we", int'(mem_we_out), 0);
    check("rst din", int'(mem_din_out), 0);
    check("rst busy", int'(busy_out), 0);
    check("rst done", int'(done_out), 0);
    check("rst ready", int'(cmd_ready_out), 1);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].tile,
              kexp, nw, first, last);
      check($sformatf("vec%0d writes", i), nw, vecs[i].k);
      check($sformatf("vec%0d first", i), first, vecs[i].first);
      check($sformatf("vec%0d last", i), last, vecs[i].last);
    end

    // Back-to-back with valid held high
    @(negedge clk_in);
    cmd_op_in = 2'd0; cmd_x_in = 6'd0; cmd_y_in = 5'd0; cmd_tile_in = 8'h11;
    cmd_valid_in = 1'b1;
    @(posedge clk_in);
    #1 cmd_x_in = 6'd39; cmd_y_in = 5'd22; cmd_tile_in = 8'h22;
    @(negedge clk_in);
    check("b2b c1 we", int'(mem_we_out), 1);
    check("b2b c1 addr", int'(mem_addr_out), 2048);
    check("b2b c1 din", int'(mem_din_out), 8'h11);
    @(negedge clk_in);
    check("b2b c2 {we,done,rdy}", int'({mem_we_out, done_out, cmd_ready_out}), 3'b011);
    @(posedge clk_in);
    #1 cmd_valid_in = 1'b0;
    @(negedge clk_in);
    check("b2b c3 we", int'(mem_we_out), 1);
    check("b2b c3 addr", int'(mem_addr_out), 2967);
    check("b2b c3 din", int'(mem_din_out), 8'h22);
    @(negedge clk_in);
    check("b2b c4 {we,done,rdy}", int'({mem_we_out, done_out, cmd_ready_out}), 3'b011);

    // Random commands against the model
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'd2 && $urandom_range(0, 3) != 0) op = 2'd1;
      run_cmd(op, 6'($urandom_range(0, 45)), 5'($urandom_range(0, 25)),
              6'($urandom_range(0, 20)), 5'($urandom_range(0, 10)), 8'($urandom),
              kexp, nw, first, last);
      check("rnd writes", nw, kexp);
    end

    // Reset during the 100th write of a CLEAR
    @(negedge clk_in);
    cmd_op_in = 2'd2; cmd_tile_in = 8'h20; cmd_valid_in = 1'b1;
    @(posedge clk_in);
    #1 cmd_valid_in = 1'b0;
    repeat (100) @(negedge clk_in);
    check("midrst we before", int'(mem_we_out), 1);
    check("midrst addr before", int'(mem_addr_out), 2048 + 99);
    rst_n_in = 1'b0;
    #1;
    check("midrst we async", int'(mem_we_out), 0);
    check("midrst busy async", int'(busy_out), 0);
    check("midrst ready", int'(cmd_ready_out), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      check("midrst quiet {we,done}", int'({mem_we_out, done_out}), 0);
    end
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("post rst {we,done,rdy}", int'({mem_we_out, done_out, cmd_ready_out}), 3'b001);
    run_cmd(2'd0, 6'd1, 5'd0, 6'd0, 5'd0, 8'h05, kexp, nw, first, last);
    check("post rst writes", nw, 1);
    check("post rst addr", first, 2049);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
